// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared types and constants for the common data bus (CDB) arbiter.
//   - CDB_packet_t : result packet broadcast to reservation stations / ROB.
//   - CDB_SRC_*    : source-index assignment of the execute units.
//   - CDB_N_SRC    : default number of functional-unit sources.
//   Optional feature macro used by importers: CDB_PRIO_SRC0_EN.
package cdb_arbiter_pkg;

  localparam int CDB_N_SRC   = 4;

  // Source 0 is the load/commit path so it can take absolute priority
  // when CDB_PRIO_SRC0_EN is defined.
  localparam int CDB_SRC_LD  = 0;
  localparam int CDB_SRC_ALU = 1;
  localparam int CDB_SRC_MUL = 2;
  localparam int CDB_SRC_BR  = 3;

  localparam int ROB_IDX_W   = 5;
  localparam int XLEN        = 32;

  typedef struct packed {
    logic                 from_commit;
    logic                 branch_result;
    logic                 load_step1;
    logic [ROB_IDX_W-1:0] dest_ROB_entry;
    logic [XLEN-1:0]      result;
  } CDB_packet_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin selector. Scans req starting at ptr,
//   wrapping modulo N_SRC; the first set bit wins. Reusable for issue select.
//   Ports:
//     req       [N_SRC] request vector
//     ptr       [PTR_W] highest-priority index this cycle (< N_SRC)
//     grant     [N_SRC] one-hot winner (zero when no request)
//     grant_idx [PTR_W] encoded winner index
//     grant_vld          any request present
module rr_arbiter #(
  parameter int N_SRC = 4,
  parameter int PTR_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_SRC-1:0] grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_vld
);

  always_comb begin
    int k;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    k         = 0;
    for (int i = 0; i < N_SRC; i++) begin
      k = (int'(ptr) + i) % N_SRC;
      if (!grant_vld && req[k]) begin
        grant[k]  = 1'b1;
        grant_idx = PTR_W'(k);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Consumer end of the FU result handshake. Picks one valid execute-unit
//   result per cycle (round-robin), returns a single-cycle yumi to it and
//   broadcasts its packet on the registered CDB one cycle later.
//   Ports:
//     clk, reset          clock (rising edge), async active-low reset
//     fu_valid [N_SRC]    per-source result valid, held until yumi
//     fu_pkt   [N_SRC]    per-source packet, stable while valid
//     flush               mispredict squash: no grant, no capture
//     fu_yumi  [N_SRC]    one-hot grant (combinational, gated by reset)
//     cdb_valid/cdb_pkt/cdb_src  registered broadcast and its source index
//   Optional feature: define CDB_PRIO_SRC0_EN to give source 0 absolute
//   priority; the round-robin then rotates over sources 1..N_SRC-1 only.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC = CDB_N_SRC,
  parameter int PTR_W = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC-1:0]        fu_valid,
  input  CDB_packet_t [N_SRC-1:0] fu_pkt,
  input  logic                    flush,
  output logic [N_SRC-1:0]        fu_yumi,
  output logic                    cdb_valid,
  output CDB_packet_t             cdb_pkt,
  output logic [PTR_W-1:0]        cdb_src
);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             cdb_valid_q, cdb_valid_d;
  CDB_packet_t      cdb_pkt_q, cdb_pkt_d;
  logic [PTR_W-1:0] cdb_src_q, cdb_src_d;

  logic [N_SRC-1:0] rr_req, rr_grant;
  logic [PTR_W-1:0] rr_idx;
  logic             rr_vld;

  logic [N_SRC-1:0] win_oh;
  logic [PTR_W-1:0] win_idx;
  logic             win_any;
  logic             ptr_adv;
  logic             grant_en;

  rr_arbiter #(.N_SRC(N_SRC), .PTR_W(PTR_W)) u_rr (
    .req       (rr_req),
    .ptr       (rr_ptr_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .grant_vld (rr_vld)
  );

`ifdef CDB_PRIO_SRC0_EN
  // Source 0 bypasses the rotation; the pointer only moves when the
  // round-robin among 1..N_SRC-1 actually wins.
  assign rr_req  = {fu_valid[N_SRC-1:1], 1'b0};
  assign win_oh  = fu_valid[0] ? N_SRC'(1) : rr_grant;
  assign win_idx = fu_valid[0] ? '0 : rr_idx;
  assign win_any = fu_valid[0] | rr_vld;
  assign ptr_adv = !fu_valid[0] && rr_vld;
`else
  assign rr_req  = fu_valid;
  assign win_oh  = rr_grant;
  assign win_idx = rr_idx;
  assign win_any = rr_vld;
  assign ptr_adv = rr_vld;
`endif

  // yumi is combinational, so it must be masked while reset is held.
  assign grant_en = win_any && !flush && reset;
  assign fu_yumi  = grant_en ? win_oh : '0;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_pkt_d   = cdb_pkt_q;
    cdb_src_d   = cdb_src_q;
    cdb_valid_d = 1'b0;
    if (grant_en) begin
      cdb_valid_d = 1'b1;
      cdb_pkt_d   = fu_pkt[win_idx];
      cdb_src_d   = win_idx;
      if (ptr_adv)
        rr_ptr_d = (win_idx == PTR_W'(N_SRC-1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_pkt_q   <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_pkt_q   <= cdb_pkt_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_pkt   = cdb_pkt_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Directed scenarios followed by randomized traffic, checked against a
//   behavioural model (integer pointer, scan-from-pointer selection).
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int PW = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        fu_valid;
  CDB_packet_t [N-1:0] fu_pkt;
  logic                flush;
  logic [N-1:0]        fu_yumi;
  logic                cdb_valid;
  CDB_packet_t         cdb_pkt;
  logic [PW-1:0]       cdb_src;

  cdb_arbiter #(.N_SRC(N), .PTR_W(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .fu_valid  (fu_valid),
    .fu_pkt    (fu_pkt),
    .flush     (flush),
    .fu_yumi   (fu_yumi),
    .cdb_valid (cdb_valid),
    .cdb_pkt   (cdb_pkt),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;

  // reference model state
  int          m_ptr;
  bit          m_vld;
  CDB_packet_t m_pkt;
  int          m_src;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_pick(input logic [N-1:0] v, input int p);
    int s;
`ifdef CDB_PRIO_SRC0_EN
    if (v[0]) return 0;
    for (int i = 0; i < N; i++) begin
      s = (p + i) % N;
      if (s != 0 && v[s]) return s;
    end
`else
    for (int i = 0; i < N; i++) begin
      s = (p + i) % N;
      if (v[s]) return s;
    end
`endif
    return -1;
  endfunction

  function automatic CDB_packet_t rand_pkt();
    CDB_packet_t p;
    p.from_commit    = 1'($urandom_range(0, 1));
    p.branch_result  = 1'($urandom_range(0, 1));
    p.load_step1     = 1'($urandom_range(0, 1));
    p.dest_ROB_entry = ROB_IDX_W'($urandom_range(0, 31));
    p.result         = $urandom;
    return p;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_vld = 0; m_pkt = '0; m_src = 0;
  endtask

  // Called at posedge+1 with inputs already applied. Checks the grant in
  // the current cycle, then the bus state just after the next edge.
  task automatic cycle(output int win);
    int w;
    w = flush ? -1 : m_pick(fu_valid, m_ptr);
    #2;
    chk("yumi", 64'(fu_yumi), (w < 0) ? 64'd0 : (64'd1 << w));
    @(posedge clk);
    if (w >= 0) begin
      m_vld = 1; m_pkt = fu_pkt[w]; m_src = w;
`ifdef CDB_PRIO_SRC0_EN
      if (w != 0) m_ptr = (w + 1) % N;
`else
      m_ptr = (w + 1) % N;
`endif
    end else begin
      m_vld = 0;
    end
    #1;
    chk("cdb_valid", 64'(cdb_valid), 64'(m_vld));
    chk("cdb_pkt",   64'(cdb_pkt),   64'(m_pkt));
    chk("cdb_src",   64'(cdb_src),   64'(m_src));
    win = w;
  endtask

  initial begin
    int w;
    logic [N-1:0] pend;
    int exp_src;

    reset = 1'b0; flush = 1'b0; fu_valid = '0; fu_pkt = '0;
    m_reset();
    // yumi must stay low during reset even with a request present
    #1 fu_valid = 4'b0001;
    #1;
    chk("rst_yumi",  64'(fu_yumi),   64'd0);
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_pkt",   64'(cdb_pkt),   64'd0);
    chk("rst_src",   64'(cdb_src),   64'd0);
    fu_valid = '0;
    @(posedge clk); #1 reset = 1'b1;

    // single request from source 0
    fu_pkt[0].dest_ROB_entry = 5'd5;
    fu_pkt[0].result         = 32'd35;
    fu_valid = 4'b0001;
    cycle(w);
    chk("t1_result", 64'(cdb_pkt.result),         64'd35);
    chk("t1_dest",   64'(cdb_pkt.dest_ROB_entry), 64'd5);
    chk("t1_src",    64'(cdb_src),                64'd0);
    fu_valid = '0; cycle(w);

    // bring pointer to 0 via a grant to source 3, then hold all valid
    for (int s = 0; s < N; s++) fu_pkt[s] = rand_pkt();
    fu_valid = 4'b1000; cycle(w);
    fu_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      cycle(w);
`ifdef CDB_PRIO_SRC0_EN
      exp_src = 0;
`else
      exp_src = i % N;
`endif
      chk("t2_src",   64'(cdb_src),   64'(exp_src));
      chk("t2_valid", 64'(cdb_valid), 64'd1);
    end
    fu_valid = '0; cycle(w);

    // pointer to 3 via source 2, then 0101 wraps to source 0 then 2
    fu_valid = 4'b0100; cycle(w);
    fu_valid = 4'b0101; cycle(w);
    chk("t3_wrap0", 64'(cdb_src), 64'd0);
    cycle(w);
`ifdef CDB_PRIO_SRC0_EN
    chk("t3_next", 64'(cdb_src), 64'd0);
`else
    chk("t3_next", 64'(cdb_src), 64'd2);
`endif
    fu_valid = '0; cycle(w);

    // flush suppresses grant and capture; source served afterwards
    fu_valid = 4'b0010; flush = 1'b1; cycle(w);
    chk("t4_flush_valid", 64'(cdb_valid), 64'd0);
    flush = 1'b0; cycle(w);
    chk("t4_after_src", 64'(cdb_src), 64'd1);
    fu_valid = '0; cycle(w);

    // reset mid-operation with a broadcast on the bus
    fu_valid = 4'b0011; cycle(w);
    fu_valid = 4'b0011 & ~(4'b1 << w);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(cdb_valid), 64'd0);
    chk("t5_rst_yumi",  64'(fu_yumi),   64'd0);
    m_reset();
    @(posedge clk); #1 reset = 1'b1;
    exp_src = m_pick(fu_valid, 0);
    cycle(w);
    chk("t5_served", 64'(cdb_src), 64'(exp_src));
    fu_valid = '0; cycle(w);

`ifdef CDB_PRIO_SRC0_EN
    // source 0 absent: rotation over 1..3
    fu_valid = 4'b1110;
    for (int i = 0; i < 4; i++) cycle(w);
    fu_valid = '0; cycle(w);
`endif

    // randomized traffic obeying the FU contract
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < N; s++)
        if (!pend[s] && $urandom_range(0, 9) < 4) begin
          pend[s]   = 1'b1;
          fu_pkt[s] = rand_pkt();
        end
      fu_valid = pend;
      flush    = ($urandom_range(0, 9) == 0);
      cycle(w);
      if (w >= 0) pend[w] = 1'b0;
    end
    flush = 1'b0; fu_valid = '0; cycle(w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
